// File: rtl/ex_div.sv
// Iterative 32-bit restoring divider for DIV/DIVU in the execute stage.
// One quotient bit per cycle; sign fix-up is applied when the result registers load.
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic              i_annul,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder
);

  // Handshake: i_start is taken only in IDLE (and only when i_annul is low);
  // o_busy covers the cycles the operation is in flight, o_done is a single
  // cycle pulse in which o_quotient/o_remainder already hold the new result.
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;

  logic [DATA_W-1:0] abs_dvd, abs_dvs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              ge;
  logic [DATA_W-1:0] step_rem, step_quo;

  // Magnitudes of the operands; 0x80000000 negates to itself and is then
  // used as an unsigned value, which gives the wrapping overflow result.
  always_comb begin
    abs_dvd = (i_signed && i_dividend[DATA_W-1]) ? -i_dividend : i_dividend;
    abs_dvs = (i_signed && i_divisor[DATA_W-1])  ? -i_divisor  : i_divisor;
  end

  // One restoring step: bring in the next dividend bit, trial-subtract.
  always_comb begin
    shifted  = {rem_q, dvd_q[DATA_W-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    diff     = shifted[DATA_W-1:0] - dvs_q;
    step_rem = ge ? diff : shifted[DATA_W-1:0];
    step_quo = {quo_q[DATA_W-2:0], ge};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_annul) begin
          if (i_divisor == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d   = S_ON;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = '0;
            dvd_d     = abs_dvd;
            dvs_d     = abs_dvs;
            neg_quo_d = i_signed & (i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1]);
            neg_rem_d = i_signed & i_dividend[DATA_W-1];
          end
        end
      end
      S_BYZERO: begin
        if (i_annul) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_END;
          quotient_d  = '0;
          remainder_d = '0;
        end
      end
      S_ON: begin
        if (i_annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q + 1'b1;
          // Final step: results go straight into the output registers so
          // they are valid in the o_done cycle.
          if (cnt_q == CNT_LAST) begin
            state_d     = S_END;
            quotient_d  = neg_quo_q ? -step_quo : step_quo;
            remainder_d = neg_rem_q ? -step_rem : step_rem;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign o_busy      = (state_q == S_BYZERO) || (state_q == S_ON);
  assign o_done      = (state_q == S_END);
  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed divides checked against a cycle-level model of
// the busy/done timeline and arithmetic results, plus literal expectations.
module tb_ex_div;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_signed;
  logic        i_annul;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ex_div #(.DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_annul     (i_annul),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- model ----------------
  function automatic void model_div(input logic sgn, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ua, ub, uq, ur;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      ua = a[31] ? -a : a;
      ub = b[31] ? -b : b;
      uq = ua / ub;
      ur = ua % ub;
      q  = (a[31] ^ b[31]) ? -uq : uq;
      r  = a[31] ? -ur : ur;
    end
  endfunction

  // m_cnt: cycles since the op was accepted (0 = nothing in flight);
  // the op is busy for m_len-1 cycles and done in cycle m_len.
  int          m_cnt = 0;
  int          m_len = 0;
  logic [31:0] m_q = 32'd0, m_r = 32'd0, m_pq = 32'd0, m_pr = 32'd0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_cnt = 0; m_len = 0; m_q = 32'd0; m_r = 32'd0;
    end else if (m_cnt == 0) begin
      if (i_start && !i_annul) begin
        m_len = (i_divisor == 32'd0) ? 2 : 33;
        model_div(i_signed, i_dividend, i_divisor, m_pq, m_pr);
        m_cnt = 1;
      end
    end else if (m_cnt < m_len) begin
      if (i_annul) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == m_len) begin
          m_q = m_pq;
          m_r = m_pr;
        end
      end
    end else begin
      m_cnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("busy", 32'(o_busy), 32'(m_cnt > 0 && m_cnt < m_len));
      check("done", 32'(o_done), 32'(m_cnt > 0 && m_cnt == m_len));
      check("quotient", o_quotient, m_q);
      check("remainder", o_remainder, m_r);
    end
  end

  // ---------------- driver tasks ----------------
  // Returns in cycle 1 of the op (start accepted at the preceding edge).
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_signed = sgn; i_dividend = a; i_divisor = b;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int first_cyc, input int exp_lat,
                           input logic [31:0] exp_q, input logic [31:0] exp_r);
    int lat = 0;
    for (int c = first_cyc; c <= 60; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_q"}, o_quotient, exp_q);
    check({name, "_r"}, o_remainder, exp_r);
  endtask

  task automatic count_done(input string name, input int cycles);
    int n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge i_clk);
      if (o_done) n++;
    end
    check(name, 32'(n), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_signed = 1'b0; i_annul = 1'b0;
    i_dividend = 32'd0; i_divisor = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_q", o_quotient, 32'd0);
    check("rst_r", o_remainder, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk_en  = 1'b1;

    start_op(1'b0, 32'd100, 32'd7);
    wait_done("u100_7", 1, 33, 32'd14, 32'd2);
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("s_m7_2", 1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done("s_7_m2", 1, 33, 32'hFFFF_FFFD, 32'd1);
    start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done("u_max_1", 1, 33, 32'hFFFF_FFFF, 32'd0);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("s_ovf", 1, 33, 32'h8000_0000, 32'd0);
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("u_big_div", 1, 33, 32'd0, 32'h8000_0000);
    start_op(1'b0, 32'hFFFF_FFFF, 32'h10);
    wait_done("u_max_16", 1, 33, 32'h0FFF_FFFF, 32'hF);

    // divide by zero, then a start in cycle 3
    start_op(1'b1, 32'd5, 32'd0);
    wait_done("div0", 1, 2, 32'd0, 32'd0);
    start_op(1'b0, 32'd9, 32'd3);
    wait_done("after_div0", 1, 33, 32'd3, 32'd0);

    // annul in cycle 10
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge i_clk);
    #1 i_annul = 1'b1;
    @(posedge i_clk); #1;
    i_annul = 1'b0;
    @(negedge i_clk);
    check("annul_idle", 32'(o_busy), 32'd0);
    count_done("annul_no_done", 40);
    check("annul_hold_q", o_quotient, 32'd3);
    check("annul_hold_r", o_remainder, 32'd0);
    start_op(1'b0, 32'd50, 32'd5);
    wait_done("restart", 1, 33, 32'd10, 32'd0);

    // annul and start together in IDLE: start dropped
    @(posedge i_clk); #1;
    i_start = 1'b1; i_annul = 1'b1; i_dividend = 32'd8; i_divisor = 32'd2;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_annul = 1'b0;
    @(negedge i_clk);
    check("annul_start_idle", 32'(o_busy), 32'd0);

    // extra starts during ON are ignored
    start_op(1'b0, 32'd1000, 32'd10);
    repeat (4) @(posedge i_clk);
    #1 i_start = 1'b1; i_dividend = 32'd7; i_divisor = 32'd0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done("extra_start", 6, 33, 32'd100, 32'd0);
    count_done("extra_start_once", 40);

    // reset asserted in cycle 20
    start_op(1'b0, 32'd100, 32'd7);
    repeat (19) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_q", o_quotient, 32'd0);
    check("midrst_r", o_remainder, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    count_done("midrst_no_done", 50);
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done("s_m100_7", 1, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    repeat (3) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
